// File: rtl/wb_stage.sv
// Writeback stage of the RV32 pipeline. Holds the MEM/WB register, absorbs the
// data-memory read response (early, same-cycle or late), aligns and extends
// load data, drives the register-file write ports and counts retirements.
// Optional: define WB_FLOAT_EN to add the floating-point write port.
module wb_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MEM_valid,
   input  logic [4:0]  MEM_op,
   input  logic [2:0]  MEM_funct3,
   input  logic [4:0]  MEM_rd,
   input  logic [31:0] MEM_aluOut,
   input  logic        stall_in,
   input  logic        flush_in,
   input  logic        DM_rvalid,
   input  logic [31:0] DM_rdata,
   input  logic        WB_wbSel,
   input  logic        WB_wbEnable,
   input  logic        WB_fwbEnable,
   output logic [4:0]  WB_op,
   output logic        WB_valid,
   output logic        wb_busy,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
`ifdef WB_FLOAT_EN
   output logic        frf_we,
   output logic [4:0]  frf_waddr,
   output logic [31:0] frf_wdata,
`endif
   output logic [63:0] instret
);

   typedef enum logic {EMPTY, FULL} buf_state_t;

   buf_state_t  buf_state, buf_next;
   logic [31:0] buf_data;
   logic [2:0]  wb_funct3;
   logic [4:0]  wb_rd;
   logic [31:0] wb_alu;
   logic        load_pending;
   logic        data_avail;
   logic [31:0] load_word;
   logic [31:0] shifted;
   logic [31:0] aligned;
   logic [31:0] wdata;
   logic        retire;

   assign load_pending = WB_valid & WB_wbSel;
   assign retire       = WB_valid & ~wb_busy;

   // Select the load data source and derive the stall.
   always_comb begin
      data_avail = (buf_state == FULL) | DM_rvalid;
      load_word  = '0;
      if (buf_state == FULL)
         load_word = buf_data;
      else if (DM_rvalid)
         load_word = DM_rdata;
      wb_busy = load_pending & ~data_avail;
   end

   // Byte-lane alignment and sign/zero extension of the load word.
   always_comb begin
      shifted = load_word >> {wb_alu[1:0], 3'b000};
      case (wb_funct3)
         3'b000:  aligned = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  aligned = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  aligned = {24'h0, shifted[7:0]};
         3'b101:  aligned = {16'h0, shifted[15:0]};
         default: aligned = shifted;
      endcase
      wdata = WB_wbSel ? aligned : wb_alu;
   end

   // MEM/WB stage register; frozen while a load waits for its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WB_valid  <= 1'b0;
         WB_op     <= '0;
         wb_funct3 <= '0;
         wb_rd     <= '0;
         wb_alu    <= '0;
      end else if (!wb_busy) begin
         if (flush_in || stall_in) begin
            WB_valid <= 1'b0;
            WB_op    <= '0;
         end else begin
            WB_valid  <= MEM_valid;
            WB_op     <= MEM_op;
            wb_funct3 <= MEM_funct3;
            wb_rd     <= MEM_rd;
            wb_alu    <= MEM_aluOut;
         end
      end
   end

   // Load-data buffer state and captured word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_state <= EMPTY;
         buf_data  <= '0;
      end else begin
         buf_state <= buf_next;
         if (buf_state == EMPTY && DM_rvalid && !load_pending)
            buf_data <= DM_rdata;
      end
   end

   // Buffer fills on an early response and drains when the load retires.
   always_comb begin
      buf_next = buf_state;
      case (buf_state)
         EMPTY: if (DM_rvalid && !load_pending) buf_next = FULL;
         FULL:  if (load_pending && retire)     buf_next = EMPTY;
         default: buf_next = EMPTY;
      endcase
   end

   // Retired-instruction counter, wraps modulo 2^64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instret <= '0;
      else if (retire)
         instret <= instret + 64'd1;
   end

   assign rf_we    = retire & WB_wbEnable & (wb_rd != 5'd0);
   assign rf_waddr = wb_rd;
   assign rf_wdata = wdata;

`ifdef WB_FLOAT_EN
   assign frf_we    = retire & WB_fwbEnable;
   assign frf_waddr = wb_rd;
   assign frf_wdata = wdata;
`else
   logic unused_fwb;
   assign unused_fwb = WB_fwbEnable;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes the expected writeback of each
// instruction; a negedge monitor pops and compares on every retirement.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MEM_valid;
   logic [4:0]  MEM_op;
   logic [2:0]  MEM_funct3;
   logic [4:0]  MEM_rd;
   logic [31:0] MEM_aluOut;
   logic        stall_in, flush_in;
   logic        DM_rvalid;
   logic [31:0] DM_rdata;
   logic        WB_wbSel, WB_wbEnable, WB_fwbEnable;
   logic [4:0]  WB_op;
   logic        WB_valid, wb_busy;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_FLOAT_EN
   logic        frf_we;
   logic [4:0]  frf_waddr;
   logic [31:0] frf_wdata;
`endif
   logic [63:0] instret;

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_FLW   = 5'b00001;
   localparam logic [4:0] OP_IMM   = 5'b00100;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_FP    = 5'b10100;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        fwe;
      int          stall;
      logic [63:0] ret;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   busy_run = 0;
   int   exp_ret = 0;
   logic done = 1'b0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_valid(MEM_valid), .MEM_op(MEM_op), .MEM_funct3(MEM_funct3),
      .MEM_rd(MEM_rd), .MEM_aluOut(MEM_aluOut),
      .stall_in(stall_in), .flush_in(flush_in),
      .DM_rvalid(DM_rvalid), .DM_rdata(DM_rdata),
      .WB_wbSel(WB_wbSel), .WB_wbEnable(WB_wbEnable), .WB_fwbEnable(WB_fwbEnable),
      .WB_op(WB_op), .WB_valid(WB_valid), .wb_busy(wb_busy),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_FLOAT_EN
      .frf_we(frf_we), .frf_waddr(frf_waddr), .frf_wdata(frf_wdata),
`endif
      .instret(instret)
   );

   // Stand-in for Controller_WB decode.
   always_comb begin
      WB_wbSel     = (WB_op == OP_LOAD) || (WB_op == OP_FLW);
      WB_wbEnable  = (WB_op == OP_LOAD) || (WB_op == OP_IMM) || (WB_op == 5'b01100) ||
                     (WB_op == 5'b01101) || (WB_op == 5'b00101) ||
                     (WB_op == 5'b11011) || (WB_op == 5'b11001);
      WB_fwbEnable = (WB_op == OP_FLW) || (WB_op == OP_FP);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: reset values, stall bound, bubbles, and scoreboard pops on retire.
   always @(negedge clk) begin
      if (done) begin
         chk("scoreboard_drained", 64'(sb.size()), 64'd0);
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end else if (!rst_n) begin
         chk("rst_valid", {63'd0, WB_valid}, 64'd0);
         chk("rst_op", {59'd0, WB_op}, 64'd0);
         chk("rst_busy", {63'd0, wb_busy}, 64'd0);
         chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
         chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
         chk("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
         chk("rst_instret", instret, 64'd0);
`ifdef WB_FLOAT_EN
         chk("rst_frf_we", {63'd0, frf_we}, 64'd0);
`endif
         busy_run = 0;
      end else if (wb_busy) begin
         busy_run++;
         chk("busy_no_write", {63'd0, rf_we}, 64'd0);
         if (busy_run > 8) chk("busy_bound", 64'(busy_run), 64'd8);
      end else if (WB_valid) begin
         if (sb.size() == 0) begin
            chk("retire_expected", 64'(sb.size()), 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rf_we", {63'd0, rf_we}, {63'd0, e.we});
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.waddr});
            chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.wdata});
            chk("stall_cycles", 64'(busy_run), 64'(e.stall));
            chk("instret", instret, e.ret);
`ifdef WB_FLOAT_EN
            chk("frf_we", {63'd0, frf_we}, {63'd0, e.fwe});
            if (e.fwe) begin
               chk("frf_waddr", {59'd0, frf_waddr}, {59'd0, e.waddr});
               chk("frf_wdata", {32'd0, frf_wdata}, {32'd0, e.wdata});
            end
`endif
         end
         busy_run = 0;
      end else begin
         chk("bubble_op", {59'd0, WB_op}, 64'd0);
         chk("bubble_rf_we", {63'd0, rf_we}, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      MEM_valid  = 1'b0;
      MEM_op     = '0;
      MEM_funct3 = '0;
      MEM_rd     = '0;
      MEM_aluOut = '0;
   endtask

   task automatic issue(input logic [4:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu);
      MEM_valid  = 1'b1;
      MEM_op     = op;
      MEM_funct3 = f3;
      MEM_rd     = rd;
      MEM_aluOut = alu;
      step();
      idle();
   endtask

   task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic fwe, input int stall);
      exp_t e;
      e.we = we; e.waddr = rd; e.wdata = wd; e.fwe = fwe; e.stall = stall;
      e.ret = 64'(exp_ret);
      sb.push_back(e);
      exp_ret++;
   endtask

   // Load whose response arrives 'delay' cycles after it enters WB.
   task automatic load(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata, input int delay,
                       input logic exp_we, input logic [31:0] exp_data, input logic exp_fwe);
      push(exp_we, rd, exp_data, exp_fwe, delay);
      issue(op, f3, rd, alu);
      repeat (delay) step();
      DM_rvalid = 1'b1;
      DM_rdata  = rdata;
      step();
      DM_rvalid = 1'b0;
   endtask

   task automatic alu_op(input logic [4:0] op, input logic [4:0] rd,
                         input logic [31:0] alu, input logic exp_we);
      push(exp_we, rd, alu, 1'b0, 0);
      issue(op, 3'b000, rd, alu);
   endtask

   initial begin
      rst_n = 1'b0;
      stall_in = 1'b0; flush_in = 1'b0;
      DM_rvalid = 1'b0; DM_rdata = '0;
      idle();
      step(); step();
      rst_n = 1'b1;
      step();

      // LB, same-cycle response
      load(OP_LOAD, 3'b000, 5'd5, 32'h0000_1003, 32'h80FF_FF00, 0, 1'b1, 32'hFFFF_FF80, 1'b0);

      // LHU, 3 cycles late; flush and a new MEM instruction while busy must not disturb WB
      push(1'b1, 5'd6, 32'h0000_BEEF, 1'b0, 3);
      issue(OP_LOAD, 3'b101, 5'd6, 32'h0000_2002);
      flush_in = 1'b1; MEM_valid = 1'b1; MEM_op = OP_IMM; MEM_rd = 5'd9; MEM_aluOut = 32'h55;
      repeat (3) step();
      idle(); flush_in = 1'b0;
      DM_rvalid = 1'b1; DM_rdata = 32'hBEEF_1234;
      step();
      DM_rvalid = 1'b0;

      // LW, response while still in MEM (buffered)
      push(1'b1, 5'd7, 32'h1234_5678, 1'b0, 0);
      DM_rvalid = 1'b1; DM_rdata = 32'h1234_5678;
      issue(OP_LOAD, 3'b010, 5'd7, 32'h0000_3000);
      DM_rvalid = 1'b0;
      step();

      // ALU results: x0 suppressed but counted, x1 written
      alu_op(OP_IMM, 5'd0, 32'd7, 1'b0);
      alu_op(OP_IMM, 5'd1, 32'h0000_DEAD, 1'b1);

      // Buffer must be empty again: stale word would give 0x78 with no stall
      load(OP_LOAD, 3'b000, 5'd8, 32'h0000_0010, 32'h0000_007F, 1, 1'b1, 32'h0000_007F, 1'b0);
      load(OP_LOAD, 3'b001, 5'd9, 32'h0000_0002, 32'h8001_0000, 0, 1'b1, 32'hFFFF_8001, 1'b0);
      load(OP_LOAD, 3'b100, 5'd10, 32'h0000_0001, 32'h0000_F000, 0, 1'b1, 32'h0000_00F0, 1'b0);

      // Bubbles: two stall cycles, then a flush
      stall_in = 1'b1; MEM_valid = 1'b1; MEM_op = OP_IMM; MEM_rd = 5'd2; MEM_aluOut = 32'h99;
      step(); step();
      stall_in = 1'b0; flush_in = 1'b1;
      step();
      flush_in = 1'b0; idle();
      step();
      alu_op(OP_IMM, 5'd2, 32'h0000_0011, 1'b1);
      alu_op(OP_STORE, 5'd3, 32'h0000_0400, 1'b0);

      // FLW, 2 cycles late; FP write only with the float port built in
`ifdef WB_FLOAT_EN
      load(OP_FLW, 3'b010, 5'd3, 32'h0000_0100, 32'h3F80_0000, 2, 1'b0, 32'h3F80_0000, 1'b1);
`else
      load(OP_FLW, 3'b010, 5'd3, 32'h0000_0100, 32'h3F80_0000, 2, 1'b0, 32'h3F80_0000, 1'b0);
`endif

      // Reset while a load waits: load dropped, counter cleared
      issue(OP_LOAD, 3'b010, 5'd11, 32'h0000_0200);
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp_ret = 0;
      step();

      // Reset while the buffer is FULL must discard the buffered word
      DM_rvalid = 1'b1; DM_rdata = 32'hBADB_AD00;
      step();
      DM_rvalid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      load(OP_LOAD, 3'b010, 5'd4, 32'h0000_0300, 32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D, 1'b0);

      step(); step();
      done = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected summary first");
      $fatal(1);
   end

endmodule
